// File: rtl/cpu_pkg.sv
// Shared CPU constants: control state numbers, ALU function codes
// and the legal decode-target check used by the sequencer and encoder.
package cpu_pkg;

   typedef enum logic [5:0] {
      S0  = 6'd0,
      S1  = 6'd1,
      S2  = 6'd2,
      S3  = 6'd3,
      S4  = 6'd4,
      S5  = 6'd5,
      S10 = 6'd10,
      S11 = 6'd11,
      S12 = 6'd12,
      S13 = 6'd13,
      S14 = 6'd14,
      S20 = 6'd20,
      S21 = 6'd21,
      S22 = 6'd22,
      S25 = 6'd25,
      S26 = 6'd26,
      S27 = 6'd27,
      S30 = 6'd30
   } state_t;

   localparam logic [3:0] ALU_NONE  = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b1010;
   localparam logic [3:0] ALU_PASSB = 4'b1101;

   function automatic logic is_legal(input logic [5:0] code);
      case (code)
         6'd10, 6'd11, 6'd12, 6'd13,
         6'd14, 6'd20, 6'd25, 6'd30: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch, decode and per-instruction
// execute states; strobes decoded from the registered state.
module control_sequencer
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] enc_state,
   input  logic       cond_pass,
   input  logic       moc,
   output logic [5:0] state,
   output logic       mar_ld,
   output logic       mdr_ld,
   output logic       ir_ld,
   output logic       pc_ld,
   output logic       rf_ld,
   output logic       flags_ld,
   output logic       mem_en,
   output logic       mem_rw,
   output logic [3:0] alu_op,
   output logic       illegal
);

   state_t cur, nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= S0;
      else        cur <= nxt;
   end

   assign state = cur;

   // Decode target is only trusted when the encoder reports a legal code
   always_comb begin
      nxt = S1;
      unique case (cur)
         S1:  nxt = S2;
         S2:  nxt = S3;
         S3:  nxt = moc ? S4 : S3;
         S4:  nxt = S5;
         S5: begin
            if (cond_pass && is_legal(enc_state))
               nxt = state_t'(enc_state);
            else
               nxt = S1;
         end
         S20: nxt = S21;
         S21: nxt = moc ? S22 : S21;
         S25: nxt = S26;
         S26: nxt = S27;
         S27: nxt = moc ? S1 : S27;
         default: nxt = S1;
      endcase
   end

   always_comb begin
      mar_ld   = 1'b0;
      mdr_ld   = 1'b0;
      ir_ld    = 1'b0;
      pc_ld    = 1'b0;
      rf_ld    = 1'b0;
      flags_ld = 1'b0;
      mem_en   = 1'b0;
      mem_rw   = 1'b0;
      alu_op   = ALU_NONE;
      illegal  = 1'b0;
      unique case (cur)
         S1: begin
            mar_ld = 1'b1;
            alu_op = ALU_PASSB;
         end
         S2: begin
            pc_ld  = 1'b1;
            alu_op = ALU_ADD;
            mem_en = 1'b1;
         end
         S3, S21: begin
            mem_en = 1'b1;
            mdr_ld = 1'b1;
         end
         S4: ir_ld = 1'b1;
         S5: illegal = cond_pass && !is_legal(enc_state);
         S10, S11, S12: begin
            rf_ld  = 1'b1;
            alu_op = ALU_ADD;
         end
         S13: begin
            flags_ld = 1'b1;
            alu_op   = ALU_SUB;
         end
         S14: begin
            rf_ld  = 1'b1;
            alu_op = ALU_PASSB;
         end
         S20, S25: begin
            mar_ld = 1'b1;
            alu_op = ALU_ADD;
         end
         S22: rf_ld = 1'b1;
         S26: begin
            mdr_ld = 1'b1;
            alu_op = ALU_PASSB;
         end
         S27: begin
            mem_en = 1'b1;
            mem_rw = 1'b1;
         end
         S30: begin
            pc_ld  = 1'b1;
            alu_op = ALU_ADD;
         end
         default: ;
      endcase
   end

endmodule
